// File: rtl/x_mem_reader_if.sv
// Bus bundle for the X-bank reader: bit-serial memory port plus the
// word-level valid/ready stream handed downstream.
interface x_mem_reader_if #(
   parameter int ADDR_W = 10,
   parameter int WORD_W = 8
) ();
   logic [1:0]        sel_x;
   logic              read_rq_x;
   logic              write_rq_x;
   logic [ADDR_W-1:0] rw_address_x;
   logic              read_data_x;
   logic [WORD_W-1:0] word_data;
   logic              word_valid;
   logic              word_ready;

   modport master (
      output sel_x, read_rq_x, write_rq_x, rw_address_x, word_data, word_valid,
      input  read_data_x, word_ready
   );

   modport slave (
      input  sel_x, read_rq_x, write_rq_x, rw_address_x, word_data, word_valid,
      output read_data_x, word_ready
   );
endinterface

// File: rtl/x_mem_reader.sv
// Read-side sequencer for the bit-serial X bank: fetches num_words words one
// bit per request starting at base_addr, assembles each word LSB first and
// hands it downstream on a valid/ready handshake.
module x_mem_reader #(
   parameter int         ADDR_W   = 10,
   parameter int         WORD_W   = 8,
   parameter int         CNT_W    = 8,
   parameter int         RD_LAT   = 1,
   parameter logic [1:0] SEL_READ = 2'd2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  num_words,
   output logic              busy,
   output logic              done,
   x_mem_reader_if.master    bus
);

   localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   // S_SKIP is the single busy cycle of an empty job, so done still lands
   // two cycles after the start edge with no memory access.
   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_WAIT, S_OUT, S_FIN, S_SKIP
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]  words_left_q, words_left_d;
   logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
   logic [WORD_W-1:0] word_q, word_d;

   // State and datapath registers; reset aborts any job immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         words_left_q <= '0;
         bit_cnt_q    <= '0;
         lat_cnt_q    <= '0;
         word_q       <= '0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         words_left_q <= words_left_d;
         bit_cnt_q    <= bit_cnt_d;
         lat_cnt_q    <= lat_cnt_d;
         word_q       <= word_d;
      end
   end

   // Next-state logic and Moore outputs of the read sequencer.
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      words_left_d = words_left_q;
      bit_cnt_d    = bit_cnt_q;
      lat_cnt_d    = lat_cnt_q;
      word_d       = word_q;

      bus.read_rq_x    = 1'b0;
      bus.write_rq_x   = 1'b0;
      bus.sel_x        = '0;
      bus.rw_address_x = addr_q;
      bus.word_data    = word_q;
      bus.word_valid   = 1'b0;
      busy             = 1'b0;
      done             = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               addr_d       = base_addr;
               words_left_d = num_words;
               bit_cnt_d    = '0;
               lat_cnt_d    = '0;
               state_d      = (num_words == '0) ? S_SKIP : S_REQ;
            end
         end
         S_SKIP: begin
            busy    = 1'b1;
            state_d = S_FIN;
         end
         S_REQ: begin
            busy          = 1'b1;
            bus.read_rq_x = 1'b1;
            bus.sel_x     = SEL_READ;
            lat_cnt_d     = '0;
            state_d       = S_WAIT;
         end
         S_WAIT: begin
            busy = 1'b1;
            if (lat_cnt_q == LAT_W'(RD_LAT - 1)) begin
               word_d[bit_cnt_q] = bus.read_data_x;
               addr_d            = addr_q + ADDR_W'(1);
               if (bit_cnt_q == BIT_W'(WORD_W - 1)) begin
                  bit_cnt_d = '0;
                  state_d   = S_OUT;
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
                  state_d   = S_REQ;
               end
            end else begin
               lat_cnt_d = lat_cnt_q + LAT_W'(1);
            end
         end
         S_OUT: begin
            busy           = 1'b1;
            bus.word_valid = 1'b1;
            if (bus.word_ready) begin
               words_left_d = words_left_q - CNT_W'(1);
               state_d      = (words_left_q == CNT_W'(1)) ? S_FIN : S_REQ;
            end
         end
         S_FIN: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_x_mem_reader.sv
// Bench for x_mem_reader: directed table of jobs with fixed timing/data
// expectations, hand-written reset/start-collision sequences, and random jobs
// checked against a word/address scoreboard built from memory contents.
module tb_x_mem_reader;
   localparam int AW = 10;
   localparam int WW = 8;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [CW-1:0] num_words = '0;
   logic          busy, done;

   x_mem_reader_if #(.ADDR_W(AW), .WORD_W(WW)) bus ();

   x_mem_reader #(.ADDR_W(AW), .WORD_W(WW), .CNT_W(CW), .RD_LAT(1), .SEL_READ(2'd2)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
      .num_words(num_words), .busy(busy), .done(done), .bus(bus.master)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic          xmem [0:(1<<AW)-1];
   logic [AW-1:0] exp_addr [$];
   logic [WW-1:0] exp_words [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Memory model: data for a request becomes valid after the request edge and is held.
   always @(posedge clk)
      if (bus.read_rq_x) bus.read_data_x <= xmem[bus.rw_address_x];

   // Reference: the sequence of bit addresses and the words they should form.
   task automatic push_expected(input logic [AW-1:0] base, input logic [CW-1:0] num);
      logic [WW-1:0] w;
      int unsigned a;
      for (int n = 0; n < int'(num); n++) begin
         w = '0;
         for (int i = 0; i < WW; i++) begin
            a = (int'(base) + n * WW + i) % (1 << AW);
            w[i] = xmem[a];
            exp_addr.push_back(AW'(a));
         end
         exp_words.push_back(w);
      end
   endtask

   // Continuous protocol monitor, sampled well after inputs settle.
   always @(negedge clk) begin
      #2;
      if (rst) begin
         chk("write_rq_zero", 32'(bus.write_rq_x), 32'd0);
         if (bus.read_rq_x) begin
            chk("sel_on_read", 32'(bus.sel_x), 32'd2);
            if (exp_addr.size() == 0) chk("unexpected_rq", 32'(bus.rw_address_x), 32'hFFFF);
            else chk("rq_addr", 32'(bus.rw_address_x), 32'(exp_addr.pop_front()));
         end else begin
            chk("sel_idle", 32'(bus.sel_x), 32'd0);
         end
         if (bus.word_valid && bus.word_ready) begin
            if (exp_words.size() == 0) chk("unexpected_word", 32'(bus.word_data), 32'hFFFF);
            else chk("word_model", 32'(bus.word_data), 32'(exp_words.pop_front()));
         end
      end
   end

   task automatic preload(input logic [AW-1:0] base, input logic [WW-1:0] pat);
      logic [AW-1:0] a;
      for (int i = 0; i < WW; i++) begin
         a = base + AW'(i);
         xmem[a] = pat[i];
      end
   endtask

   // Runs one job; cycle 1 is the first cycle after the start edge.
   // stall<0 means random ready, otherwise ready is held low for 'stall' valid cycles.
   task automatic run_job(input logic [AW-1:0] base, input logic [CW-1:0] num, input int stall,
                          output int first_v, output int done_c, output logic [WW-1:0] word,
                          output bit busy_ok, output bit stable_ok);
      int vcnt;
      bit have;
      logic [WW-1:0] held;
      first_v = 0; done_c = 0; word = '0; busy_ok = 1; stable_ok = 1; vcnt = 0; have = 0;
      held = '0;
      push_expected(base, num);
      @(negedge clk); start = 1'b1; base_addr = base; num_words = num;
      @(negedge clk); start = 1'b0;
      for (int c = 1; c < 3000 && done_c == 0; c++) begin
         if (c > 1) @(negedge clk);
         if (done) done_c = c;
         if (busy !== (done_c == 0)) busy_ok = 0;
         if (bus.word_valid) begin
            if (first_v == 0) begin first_v = c; word = bus.word_data; end
            if (!have) begin held = bus.word_data; have = 1; end
            else if (bus.word_data !== held) stable_ok = 0;
            if (bus.read_rq_x) stable_ok = 0;
            if (stall < 0) bus.word_ready = 1'($urandom_range(0, 1));
            else bus.word_ready = (vcnt >= stall);
            if (bus.word_ready) begin have = 0; vcnt = 0; end
            else vcnt++;
         end else begin
            bus.word_ready = (stall < 0) ? 1'($urandom_range(0, 1)) : 1'b1;
         end
      end
   endtask

   typedef struct {
      logic [AW-1:0] base;
      logic [WW-1:0] pat;
      logic [CW-1:0] num;
      int            stall;
      logic [WW-1:0] exp_word;
      int            exp_valid;
      int            exp_done;
   } vec_t;

   vec_t vecs [5];

   initial begin
      int fv, dc;
      logic [WW-1:0] wd;
      bit bok, sok, ok;

      vecs[0] = '{base: 10'd1,    pat: 8'h4D, num: 8'd1, stall: 0, exp_word: 8'h4D, exp_valid: 17, exp_done: 18};
      vecs[1] = '{base: 10'd1,    pat: 8'h4D, num: 8'd1, stall: 5, exp_word: 8'h4D, exp_valid: 17, exp_done: 23};
      vecs[2] = '{base: 10'd1020, pat: 8'hEB, num: 8'd1, stall: 0, exp_word: 8'hEB, exp_valid: 17, exp_done: 18};
      vecs[3] = '{base: 10'd5,    pat: 8'h00, num: 8'd0, stall: 0, exp_word: 8'h00, exp_valid: 0,  exp_done: 2};
      vecs[4] = '{base: 10'd100,  pat: 8'hA5, num: 8'd1, stall: 2, exp_word: 8'hA5, exp_valid: 17, exp_done: 20};

      for (int i = 0; i < (1 << AW); i++) xmem[i] = 1'b0;
      bus.word_ready = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_rq", 32'(bus.read_rq_x), 0);
      chk("rst_addr", 32'(bus.rw_address_x), 0);
      chk("rst_word", 32'(bus.word_data), 0);
      chk("rst_valid", 32'(bus.word_valid), 0);
      rst = 1'b1;

      // Directed table
      for (int v = 0; v < 5; v++) begin
         preload(vecs[v].base, vecs[v].pat);
         run_job(vecs[v].base, vecs[v].num, vecs[v].stall, fv, dc, wd, bok, sok);
         chk($sformatf("v%0d_word", v), 32'(wd), 32'(vecs[v].exp_word));
         chk($sformatf("v%0d_valid_cyc", v), 32'(fv), 32'(vecs[v].exp_valid));
         chk($sformatf("v%0d_done_cyc", v), 32'(dc), 32'(vecs[v].exp_done));
         chk($sformatf("v%0d_busy", v), 32'(bok), 1);
         chk($sformatf("v%0d_stable", v), 32'(sok), 1);
         chk($sformatf("v%0d_drained", v), 32'(exp_addr.size() + exp_words.size()), 0);
      end

      // Start during the done cycle must be ignored
      preload(10'd300, 8'h3C);
      run_job(10'd300, 8'd1, 0, fv, dc, wd, bok, sok);
      start = 1'b1; base_addr = 10'd40; num_words = 8'd3;
      @(negedge clk); start = 1'b0;
      ok = 1;
      repeat (4) begin
         @(negedge clk);
         if (busy || bus.read_rq_x || done) ok = 0;
      end
      chk("fin_start_ignored", 32'(ok), 1);
      chk("fin_word", 32'(wd), 32'h3C);

      // Randomised jobs against the scoreboard
      for (int i = 0; i < (1 << AW); i++) xmem[i] = 1'($urandom_range(0, 1));
      for (int j = 0; j < 30; j++) begin
         run_job(10'($urandom_range(0, 1023)), 8'($urandom_range(1, 3)), -1, fv, dc, wd, bok, sok);
         chk("rnd_done_seen", 32'(dc != 0), 1);
         chk("rnd_busy", 32'(bok), 1);
         chk("rnd_stable", 32'(sok), 1);
         chk("rnd_drained", 32'(exp_addr.size() + exp_words.size()), 0);
      end

      // Two-word job: ignored restart, then reset during word 2
      push_expected(10'd200, 8'd2);
      bus.word_ready = 1'b1;
      @(negedge clk); start = 1'b1; base_addr = 10'd200; num_words = 8'd2;
      @(negedge clk); start = 1'b0;
      ok = 1;
      for (int c = 1; c <= 22; c++) begin
         if (c > 1) @(negedge clk);
         if (c == 5) begin start = 1'b1; base_addr = 10'd10; num_words = 8'd7; end
         else start = 1'b0;
         if (done) ok = 0;
      end
      chk("t5_rq_before_rst", 32'(bus.read_rq_x), 1);
      chk("t5_one_word_out", 32'(exp_words.size()), 1);
      #1 rst = 1'b0;
      #1;
      chk("t5_rq_drop", 32'(bus.read_rq_x), 0);
      chk("t5_sel_zero", 32'(bus.sel_x), 0);
      chk("t5_addr_zero", 32'(bus.rw_address_x), 0);
      chk("t5_word_zero", 32'(bus.word_data), 0);
      chk("t5_valid_zero", 32'(bus.word_valid), 0);
      chk("t5_busy_zero", 32'(busy), 0);
      repeat (3) begin @(negedge clk); if (done || busy) ok = 0; end
      exp_addr.delete();
      exp_words.delete();
      rst = 1'b1;
      repeat (5) begin @(negedge clk); if (done || busy) ok = 0; end
      chk("t5_no_done", 32'(ok), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
